// File: rtl/async_fifo_reader_pkg.sv
// Shared definitions for the FIFO read-port drain engine.
package async_fifo_reader_pkg;

    // Buffer occupancy states; the encoding doubles as the buffered-word level.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int unsigned LEVEL_W = 2;

endpackage

// File: rtl/async_fifo_reader.sv
// Drains the read port of the clock-crossing FIFO into a 2-entry buffer
// and presents the words as a valid/ready stream.
module async_fifo_reader
    import async_fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CNT_SZ = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               empty_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               rd_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    input  logic               ready_i,
    input  logic               flush_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic [CNT_SZ-1:0]  count_o
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    head_q, head_d;
    logic [WIDTH-1:0]    skid_q, skid_d;
    logic [CNT_SZ-1:0]   count_q, count_d;
    logic                rst_hold_q;
    logic                push;
    logic                pop;

    // FIFO strobe and handshake events. rst_hold_q keeps the strobe low
    // for the cycle after reset release so that cycle still shows reset values.
    always_comb begin
        rd_o = ~empty_i & ~flush_i & ~rst_i & ~rst_hold_q & (state_q != ST_TWO);
        push = rd_o & ~empty_i;
        pop  = valid_o & ready_i;
    end

    // Next-state, buffer data and delivered-word counter.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q + CNT_SZ'(pop);
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    head_d  = data_i;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = data_i;
                end else if (push) begin
                    state_d = ST_TWO;
                    skid_d  = data_i;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                    head_d  = '0;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                head_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Flush discards buffered words; a same-cycle pop was still seen downstream.
        if (flush_i) begin
            state_d = ST_EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            count_q    <= '0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            rst_hold_q <= 1'b0;
        end
    end

    // Registered stream outputs.
    always_comb begin
        valid_o = (state_q != ST_EMPTY);
        data_o  = head_q;
        level_o = LEVEL_W'(state_q);
        count_o = count_q;
    end

endmodule

// File: tb/tb_async_fifo_reader.sv
// Self-checking bench: a queue-based FIFO model feeds the DUT and a
// scoreboard holds the words expected on the stream, in order.
module tb_async_fifo_reader;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_i;
    logic             empty_i;
    logic [WIDTH-1:0] data_i;
    logic             rd_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic             flush_i;
    logic [1:0]       level_o;
    logic [15:0]      count_o;

    logic             rd4;
    logic [WIDTH-1:0] data4;
    logic             valid4;
    logic [1:0]       level4;
    logic [3:0]       count4;

    logic [WIDTH-1:0] fifo[$];
    logic [WIDTH-1:0] sb[$];
    logic             gate;
    int               total;
    int               bad;
    int unsigned      exp_count;

    async_fifo_reader #(.WIDTH(WIDTH), .CNT_SZ(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .empty_i(empty_i), .data_i(data_i),
        .rd_o(rd_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .flush_i(flush_i), .level_o(level_o), .count_o(count_o)
    );

    async_fifo_reader #(.WIDTH(WIDTH), .CNT_SZ(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .empty_i(empty_i), .data_i(data_i),
        .rd_o(rd4), .data_o(data4), .valid_o(valid4), .ready_i(ready_i),
        .flush_i(flush_i), .level_o(level4), .count_o(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_fifo();
        empty_i = gate || (fifo.size() == 0);
        data_i  = empty_i ? '0 : fifo[0];
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        fifo.push_back(w);
        sb.push_back(w);
        drive_fifo();
    endtask

    // One clock: the FIFO model drops its head on a strobe, then returns at the next negedge.
    task automatic advance();
        logic push;
        push = rd_o && !empty_i;
        @(posedge clk);
        #1;
        if (push && fifo.size() > 0) void'(fifo.pop_front());
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp;
        rst_i = 1'b1;
        load(8'h5A);
        #1;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (rd_o !== 1'b0) begin bad++; $display("FAIL reset_rd c=%0d got=%b want=0", c, rd_o); end
            advance();
        end
        rst_i = 1'b0;
        #1;
        total++;
        if ({rd_o, valid_o, data_o, level_o, count_o} !== '0)
            begin bad++; $display("FAIL reset_outs got rd=%b v=%b d=%h l=%0d c=%0d want all 0", rd_o, valid_o, data_o, level_o, count_o); end
        advance();
        total++;
        if (rd_o !== 1'b1) begin bad++; $display("FAIL reset_first_rd got=%b want=1", rd_o); end
        advance();
        total++;
        exp = sb.pop_front();
        if (valid_o !== 1'b1 || data_o !== exp) begin bad++; $display("FAIL reset_word got v=%b d=%h want v=1 d=%h", valid_o, data_o, exp); end
        advance();
        exp_count = 1;
        total++;
        if (count_o !== 16'(exp_count) || valid_o !== 1'b0) begin bad++; $display("FAIL reset_count got c=%0d v=%b want c=%0d v=0", count_o, valid_o, exp_count); end
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] exp;
        ready_i = 1'b1;
        load(8'h11); load(8'h22); load(8'h33);
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                total++;
                if (rd_o !== 1'b1) begin bad++; $display("FAIL stream_first_rd got=%b want=1", rd_o); end
            end
            if (c >= 1 && c <= 3) begin
                total++;
                exp = sb.pop_front();
                if (valid_o !== 1'b1 || data_o !== exp) begin bad++; $display("FAIL stream_word c=%0d got v=%b d=%h want v=1 d=%h", c, valid_o, data_o, exp); end
            end
            if (c == 3) begin
                total++;
                if (rd_o !== 1'b0 || empty_i !== 1'b1) begin bad++; $display("FAIL stream_rd_empty got rd=%b want 0", rd_o); end
            end
            if (c == 4) begin
                total++;
                if (valid_o !== 1'b0) begin bad++; $display("FAIL stream_idle got v=%b want 0", valid_o); end
            end
            advance();
        end
        exp_count += 3;
        total++;
        if (count_o !== 16'(exp_count)) begin bad++; $display("FAIL stream_count got=%0d want=%0d", count_o, exp_count); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp;
        int pulses, delivered;
        ready_i = 1'b0;
        load(8'hB1); load(8'hB2); load(8'hB3); load(8'hB4);
        #1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (rd_o && !empty_i) pulses++;
            advance();
        end
        total++;
        if (pulses != 2) begin bad++; $display("FAIL bp_pulses got=%0d want=2", pulses); end
        total++;
        if (level_o !== 2'd2 || valid_o !== 1'b1 || data_o !== sb[0])
            begin bad++; $display("FAIL bp_hold got l=%0d v=%b d=%h want l=2 v=1 d=%h", level_o, valid_o, data_o, sb[0]); end
        ready_i = 1'b1;
        #1;
        delivered = 0;
        for (int c = 0; c < 12; c++) begin
            if (valid_o && ready_i) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL bp_extra got d=%h want none", data_o); end
                else begin
                    exp = sb.pop_front();
                    if (data_o !== exp) begin bad++; $display("FAIL bp_order got=%h want=%h", data_o, exp); end
                end
                delivered++;
            end
            advance();
        end
        exp_count += 4;
        total++;
        if (delivered != 4 || count_o !== 16'(exp_count) || level_o !== 2'd0)
            begin bad++; $display("FAIL bp_drain got n=%0d c=%0d l=%0d want n=4 c=%0d l=0", delivered, count_o, level_o, exp_count); end
    endtask

    task automatic test_flush();
        logic [WIDTH-1:0] exp;
        ready_i = 1'b0;
        load(8'hA1); load(8'hA2); load(8'hA3);
        #1;
        for (int c = 0; c < 3; c++) advance();
        total++;
        if (level_o !== 2'd2) begin bad++; $display("FAIL flush_pre_level got=%0d want=2", level_o); end
        ready_i = 1'b1;
        flush_i = 1'b1;
        #1;
        total++;
        exp = sb.pop_front();
        if (rd_o !== 1'b0 || data_o !== exp) begin bad++; $display("FAIL flush_cycle got rd=%b d=%h want rd=0 d=%h", rd_o, data_o, exp); end
        void'(sb.pop_front());
        advance();
        flush_i = 1'b0;
        exp_count += 1;
        total++;
        if (level_o !== 2'd0 || valid_o !== 1'b0 || count_o !== 16'(exp_count))
            begin bad++; $display("FAIL flush_after got l=%0d v=%b c=%0d want l=0 v=0 c=%0d", level_o, valid_o, count_o, exp_count); end
        #1;
        advance();
        total++;
        exp = sb.pop_front();
        if (valid_o !== 1'b1 || data_o !== exp) begin bad++; $display("FAIL flush_next got v=%b d=%h want v=1 d=%h", valid_o, data_o, exp); end
        advance();
        exp_count += 1;
        total++;
        if (count_o !== 16'(exp_count)) begin bad++; $display("FAIL flush_count got=%0d want=%0d", count_o, exp_count); end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] exp;
        ready_i = 1'b0;
        load(8'hC1); load(8'hC2); load(8'hC3);
        #1;
        for (int c = 0; c < 3; c++) advance();
        rst_i = 1'b1;
        #1;
        advance();
        rst_i = 1'b0;
        void'(sb.pop_front());
        void'(sb.pop_front());
        #1;
        total++;
        if ({rd_o, valid_o, data_o, level_o, count_o} !== '0)
            begin bad++; $display("FAIL rstmid_outs got rd=%b v=%b d=%h l=%0d c=%0d want all 0", rd_o, valid_o, data_o, level_o, count_o); end
        ready_i = 1'b1;
        advance();
        advance();
        total++;
        exp = sb.pop_front();
        if (valid_o !== 1'b1 || data_o !== exp) begin bad++; $display("FAIL rstmid_word got v=%b d=%h want v=1 d=%h", valid_o, data_o, exp); end
        advance();
        exp_count = 1;
        total++;
        if (count_o !== 16'(exp_count)) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", count_o, exp_count); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp;
        int delivered;
        rst_i = 1'b1;
        #1;
        advance();
        rst_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 17; i++) load(WIDTH'(8'h40 + i));
        #1;
        delivered = 0;
        for (int c = 0; c < 40 && delivered < 17; c++) begin
            if (valid_o && ready_i) begin
                total++;
                exp = sb.pop_front();
                if (data_o !== exp) begin bad++; $display("FAIL wrap_word got=%h want=%h", data_o, exp); end
                delivered++;
            end
            advance();
        end
        exp_count = 17;
        total++;
        if (delivered != 17 || count_o !== 16'(exp_count) || count4 !== 4'd1)
            begin bad++; $display("FAIL wrap_count got n=%0d c16=%0d c4=%0d want n=17 c16=17 c4=1", delivered, count_o, count4); end
    endtask

    task automatic test_empty_edge();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 10; i++) load(WIDTH'($urandom_range(1, 255)));
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            gate = c[0];
            drive_fifo();
            ready_i = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (empty_i && rd_o) begin bad++; $display("FAIL edge_rd_on_empty c=%0d got rd=1 want 0", c); end
            if (valid_o && ready_i) begin
                total++;
                exp = sb.pop_front();
                if (data_o !== exp) begin bad++; $display("FAIL edge_word got=%h want=%h", data_o, exp); end
            end
            advance();
        end
        gate = 1'b0;
        drive_fifo();
        exp_count += 10;
        total++;
        if (sb.size() != 0 || count_o !== 16'(exp_count))
            begin bad++; $display("FAIL edge_final got left=%0d c=%0d want left=0 c=%0d", sb.size(), count_o, exp_count); end
    endtask

    initial begin
        total = 0; bad = 0; exp_count = 0; gate = 1'b0;
        rst_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
        drive_fifo();
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_empty_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
